ringbuffer_ctrl: RTL and testbench
==================================

Name: ringbuffer_ctrl

Overview:
- Sequences the capture ringbuffer between the LPC decoder (producer) and the UART serializer (consumer).
- Writes each decoded record into the record RAM at the ringbuffer's write_addr, then pulses write_done.
- Fetches records from the RAM at read_addr, presents them on a valid/ready port, then pulses read_done.
- The LPC bus cannot be stalled, so records arriving when the buffer is full or the write path is busy are dropped and counted.

Parameters:
- BITS, 7: ringbuffer address width; RAM depth is 2^BITS.
- WIDTH, 32: record width in bits.
- CNT_BITS, 16: drop counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  one-cycle strobe; a decoded LPC record is present.
- in_data  in  WIDTH  record payload.
- rb_write_addr  in  BITS  ringbuffer write pointer.
- rb_read_addr  in  BITS  ringbuffer read pointer.
- rb_empty  in  1  ringbuffer empty.
- rb_full  in  1  ringbuffer full.
- rb_write_done  out  1  pointer advance pulse to ringbuffer write_done.
- rb_read_done  out  1  pointer advance pulse to ringbuffer read_done.
- ram_wr_en  out  1  RAM write enable.
- ram_wr_addr  out  BITS  RAM write address.
- ram_wr_data  out  WIDTH  RAM write data.
- ram_rd_addr  out  BITS  RAM read address; RAM read is synchronous, 1-cycle latency.
- ram_rd_data  in  WIDTH  RAM read data.
- out_valid  out  1  record available to the serializer.
- out_data  out  WIDTH  record to the serializer.
- out_ready  in  1  serializer accepts the record.
- drop_count  out  CNT_BITS  saturating count of dropped records.

Behaviour:
- Reset (reset=0, async): all outputs 0; both FSMs go to IDLE; drop_count=0.
- Ringbuffer pointers advance on the rising edge of write_done/read_done and are stable by the next clk edge. Every done pulse is exactly 1 clk high, followed by at least 1 clk low.
- Write FSM:
  - W_IDLE: on in_valid & !rb_full, register ram_wr_addr=rb_write_addr and ram_wr_data=in_data, assert ram_wr_en for 1 cycle, then go to W_COMMIT.
  - W_COMMIT: rb_write_done=1; go to W_SETTLE.
  - W_SETTLE: rb_write_done=0; go to W_IDLE.
  - Net: one record accepted per 3 cycles.
- Drops: in_valid while rb_full, or while in W_COMMIT/W_SETTLE, drops the record and increments drop_count, saturating at 2^CNT_BITS-1. The RAM is not written and pointers are untouched.
- Read FSM:
  - R_IDLE: if !rb_empty, drive ram_rd_addr=rb_read_addr and go to R_FETCH.
  - R_FETCH: wait one cycle for RAM data; go to R_PRESENT.
  - R_PRESENT: out_data=ram_rd_data (registered on entry), out_valid=1; hold until out_ready=1.
  - On the out_valid & out_ready cycle: out_valid=0 and go to R_RELEASE.
  - R_RELEASE: rb_read_done=1 for 1 cycle; go to R_SETTLE.
  - R_SETTLE: rb_read_done=0; return to R_IDLE, where rb_empty is re-evaluated.
- out_data is stable while out_valid=1. out_valid never drops without a handshake.
- Simultaneous write and read are independent. The same address is never written and read in flight together, because read only starts when !rb_empty, i.e. on a committed record.
- Full boundary: after 2^BITS-1 accepted records, rb_full=1 and further in_valid are dropped. One read_done clears full.
- Wrap-around is handled by the ringbuffer; the controller only forwards the addresses.
- Reset mid-operation: pending done pulses are aborted, out_valid drops immediately, and any in-flight record is lost (not counted).

Optional Feature:
- Macro: RINGBUFFER_CTRL_DROPCNT_EN.
- Defined: drop_count behaves as specified above.
- Undefined: drop_count is tied to 0, the counter logic is removed, and drops still occur silently.

Test Plan:
- Reset, then in_valid with in_data=0xA5A5_0001 -> ram_wr_en with addr 0, data 0xA5A5_0001. rb_write_done pulses 2 cycles later; rb_write_addr=1, rb_empty=0.
- One record buffered, out_ready=1 -> out_valid asserts 2 cycles after R_IDLE with out_data=0xA5A5_0001. rb_read_done then pulses once; rb_read_addr=1, rb_empty=1.
- 127 records written with out_ready=0 -> rb_full=1. The 128th in_valid is dropped, drop_count=1, no ram_wr_en.
- in_valid on two consecutive cycles -> first record written, second dropped, drop_count=1.
- out_ready held 0 for 10 cycles during R_PRESENT -> out_valid and out_data stable for all 10 cycles, no rb_read_done.
- reset=0 asserted during R_PRESENT and W_COMMIT -> out_valid, rb_write_done and drop_count all 0 immediately. Normal operation resumes after release.

Source files
------------

// File: rtl/ringbuffer_ctrl.sv
// Capture ringbuffer sequencer between the LPC decoder and the UART serializer.
// RINGBUFFER_CTRL_DROPCNT_EN enables the saturating drop counter.
module ringbuffer_ctrl #(
  parameter int BITS     = 7,
  parameter int WIDTH    = 32,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    in_data,
  input  logic [BITS-1:0]     rb_write_addr,
  input  logic [BITS-1:0]     rb_read_addr,
  input  logic                rb_empty,
  input  logic                rb_full,
  output logic                rb_write_done,
  output logic                rb_read_done,
  output logic                ram_wr_en,
  output logic [BITS-1:0]     ram_wr_addr,
  output logic [WIDTH-1:0]    ram_wr_data,
  output logic [BITS-1:0]     ram_rd_addr,
  input  logic [WIDTH-1:0]    ram_rd_data,
  output logic                out_valid,
  output logic [WIDTH-1:0]    out_data,
  input  logic                out_ready,
  output logic [CNT_BITS-1:0] drop_count
);

  typedef enum logic [1:0] {
    W_IDLE, W_COMMIT, W_SETTLE
  } wstate_t;

  typedef enum logic [2:0] {
    R_IDLE, R_FETCH, R_PRESENT, R_RELEASE, R_SETTLE
  } rstate_t;

  wstate_t          w_q, w_d;
  logic             wr_en_d, wr_done_d;
  logic [BITS-1:0]  wr_addr_d;
  logic [WIDTH-1:0] wr_data_d;

  rstate_t          r_q, r_d;
  logic             ov_d, rd_done_d;
  logic [WIDTH-1:0] od_d;
  logic [BITS-1:0]  rd_addr_q, rd_addr_d;

  always_comb begin
    w_d       = w_q;
    wr_en_d   = 1'b0;
    wr_done_d = 1'b0;
    wr_addr_d = ram_wr_addr;
    wr_data_d = ram_wr_data;
    unique case (w_q)
      W_IDLE: begin
        if (in_valid && !rb_full) begin
          wr_en_d   = 1'b1;
          wr_addr_d = rb_write_addr;
          wr_data_d = in_data;
          w_d       = W_COMMIT;
        end
      end
      W_COMMIT: begin
        wr_done_d = 1'b1;
        w_d       = W_SETTLE;
      end
      W_SETTLE: w_d = W_IDLE;
      default:  w_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_q           <= W_IDLE;
      ram_wr_en     <= 1'b0;
      rb_write_done <= 1'b0;
      ram_wr_addr   <= '0;
      ram_wr_data   <= '0;
    end else begin
      w_q           <= w_d;
      ram_wr_en     <= wr_en_d;
      rb_write_done <= wr_done_d;
      ram_wr_addr   <= wr_addr_d;
      ram_wr_data   <= wr_data_d;
    end
  end

  // The RAM samples the address as the FSM leaves R_IDLE, so pass it through.
  assign ram_rd_addr = (r_q == R_IDLE) ? rb_read_addr : rd_addr_q;

  always_comb begin
    r_d       = r_q;
    ov_d      = out_valid;
    od_d      = out_data;
    rd_done_d = 1'b0;
    rd_addr_d = rd_addr_q;
    unique case (r_q)
      R_IDLE: begin
        if (!rb_empty) begin
          rd_addr_d = rb_read_addr;
          r_d       = R_FETCH;
        end
      end
      R_FETCH: begin
        ov_d = 1'b1;
        od_d = ram_rd_data;
        r_d  = R_PRESENT;
      end
      R_PRESENT: begin
        if (out_ready) begin
          ov_d      = 1'b0;
          rd_done_d = 1'b1;
          r_d       = R_RELEASE;
        end
      end
      R_RELEASE: r_d = R_SETTLE;
      R_SETTLE:  r_d = R_IDLE;
      default:   r_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q          <= R_IDLE;
      out_valid    <= 1'b0;
      out_data     <= '0;
      rb_read_done <= 1'b0;
      rd_addr_q    <= '0;
    end else begin
      r_q          <= r_d;
      out_valid    <= ov_d;
      out_data     <= od_d;
      rb_read_done <= rd_done_d;
      rd_addr_q    <= rd_addr_d;
    end
  end

`ifdef RINGBUFFER_CTRL_DROPCNT_EN
  logic drop;
  assign drop = in_valid && ((w_q != W_IDLE) || rb_full);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_count <= '0;
    end else if (drop && (drop_count != {CNT_BITS{1'b1}})) begin
      drop_count <= drop_count + CNT_BITS'(1);
    end
  end
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_ringbuffer_ctrl.sv
// Bench for ringbuffer_ctrl: ringbuffer/RAM environment, timing-rule model,
// per-cycle compare plus directed literal checks.
module tb_ringbuffer_ctrl;
  localparam int BITS = 7;
  localparam int WIDTH = 32;
  localparam int CNT_BITS = 16;
  localparam int DEPTH = 1 << BITS;
`ifdef RINGBUFFER_CTRL_DROPCNT_EN
  localparam bit DC_EN = 1'b1;
`else
  localparam bit DC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic out_ready = 1'b0;
  logic [BITS-1:0] rb_write_addr, rb_read_addr, ram_wr_addr, ram_rd_addr;
  logic rb_empty, rb_full, rb_write_done, rb_read_done, ram_wr_en, out_valid;
  logic [WIDTH-1:0] ram_wr_data, ram_rd_data, out_data;
  logic [CNT_BITS-1:0] drop_count;

  always #5 clk = ~clk;

  ringbuffer_ctrl #(.BITS(BITS), .WIDTH(WIDTH), .CNT_BITS(CNT_BITS)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data),
    .rb_write_addr(rb_write_addr), .rb_read_addr(rb_read_addr),
    .rb_empty(rb_empty), .rb_full(rb_full),
    .rb_write_done(rb_write_done), .rb_read_done(rb_read_done),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data), .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready),
    .drop_count(drop_count)
  );

  // environment: ringbuffer pointers and synchronous RAM
  logic [BITS-1:0] wp, rp;
  int cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_q;
  assign rb_write_addr = wp;
  assign rb_read_addr = rp;
  assign rb_empty = (cnt == 0);
  assign rb_full = (cnt == DEPTH - 1);
  assign ram_rd_data = rd_q;

  // model: cycle stamps of last accept, read start and read handshake
  int cyc, t_acc, t_start, t_hs;
  int unsigned drops;
  logic [WIDTH-1:0] sb [$];
  logic [BITS-1:0] exp_waddr;
  logic [WIDTH-1:0] exp_wdata;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp <= '0; rp <= '0; cnt <= 0; rd_q <= '0;
      cyc <= 0; t_acc <= -10; t_start <= -10; t_hs <= -10;
      drops <= 0; exp_waddr <= '0; exp_wdata <= '0;
      sb.delete();
    end else begin
      if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
      rd_q <= mem[ram_rd_addr];
      if (rb_write_done) wp <= wp + 1'b1;
      if (rb_read_done) rp <= rp + 1'b1;
      cnt <= cnt + (rb_write_done ? 1 : 0) - (rb_read_done ? 1 : 0);
      cyc <= cyc + 1;
      if (in_valid) begin
        if (!rb_full && cyc >= t_acc + 3) begin
          t_acc <= cyc;
          exp_waddr <= wp;
          exp_wdata <= in_data;
          sb.push_back(in_data);
        end else if (drops != 65535) begin
          drops <= drops + 1;
        end
      end
      if (t_start <= t_hs && cyc >= t_hs + 3 && !rb_empty) begin
        t_start <= cyc;
      end else if (t_start > t_hs && cyc >= t_start + 2 && out_ready) begin
        t_hs <= cyc;
        void'(sb.pop_front());
      end
    end
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  logic [15:0] exp_dc;
  assign exp_dc = DC_EN ? drops[15:0] : 16'd0;

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_wr_en", ram_wr_en, 0);
      chk("rst_wdone", rb_write_done, 0);
      chk("rst_rdone", rb_read_done, 0);
      chk("rst_ovalid", out_valid, 0);
      chk("rst_odata", out_data, 0);
      chk("rst_dcount", drop_count, 0);
      chk("rst_rdaddr", ram_rd_addr, 0);
    end else begin
      chk("wr_en", ram_wr_en, cyc == t_acc + 1);
      chk("write_done", rb_write_done, cyc == t_acc + 2);
      chk("read_done", rb_read_done, cyc == t_hs + 1);
      chk("out_valid", out_valid, t_start > t_hs && cyc >= t_start + 2);
      chk("drop_count", drop_count, exp_dc);
      if (cyc == t_acc + 1) begin
        chk("wr_addr", ram_wr_addr, exp_waddr);
        chk("wr_data", ram_wr_data, exp_wdata);
      end
      if (t_start > t_hs && cyc >= t_start + 2)
        chk("out_data", out_data, sb[0]);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] held;

  initial begin
    repeat (3) step();
    reset = 1'b1;
    step();

    // single write: wr_en next cycle, write_done the cycle after
    in_valid = 1'b1; in_data = 32'hA5A5_0001;
    step();
    in_valid = 1'b0;
    chk("t1_wr_en", ram_wr_en, 1);
    chk("t1_wr_addr", ram_wr_addr, 0);
    chk("t1_wr_data", ram_wr_data, 32'hA5A5_0001);
    step();
    chk("t1_wdone", rb_write_done, 1);
    step();
    chk("t1_wp", rb_write_addr, 1);
    chk("t1_empty", rb_empty, 0);

    // read presented two cycles after idle sees the record, held 10 cycles
    step();
    chk("t2_ov_fetch", out_valid, 0);
    step();
    chk("t2_ov", out_valid, 1);
    chk("t2_odata", out_data, 32'hA5A5_0001);
    held = out_data;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t2_hold_ov", out_valid, 1);
      chk("t2_hold_od", out_data, held);
      chk("t2_hold_rd", rb_read_done, 0);
    end
    out_ready = 1'b1;
    step();
    chk("t2_ov_drop", out_valid, 0);
    chk("t2_rdone", rb_read_done, 1);
    step();
    chk("t2_rdone_low", rb_read_done, 0);
    chk("t2_rp", rb_read_addr, 1);
    chk("t2_empty", rb_empty, 1);

    // back-to-back strobes: second one is dropped
    step();
    in_valid = 1'b1; in_data = 32'hB000_0000;
    step();
    in_data = 32'hB000_0001;
    step();
    in_valid = 1'b0;
    chk("t3_no_wr", ram_wr_en, 0);
    chk("t3_dcount", drop_count, DC_EN ? 1 : 0);
    repeat (12) step();
    chk("t3_rp", rb_read_addr, 2);

    // reset during present and during the write_done pulse
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hC0DE_0001;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    chk("t4_ov_pre", out_valid, 1);
    in_valid = 1'b1; in_data = 32'hC0DE_0002;
    step();
    in_valid = 1'b0;
    step();
    chk("t4_wdone_pre", rb_write_done, 1);
    reset = 1'b0;
    #1;
    chk("t4_ov", out_valid, 0);
    chk("t4_wdone", rb_write_done, 0);
    chk("t4_dcount", drop_count, 0);
    repeat (2) step();
    reset = 1'b1;
    step();

    // fill to full with the reader stalled, then one more strobe
    for (int i = 0; i < DEPTH - 1; i++) begin
      in_valid = 1'b1; in_data = 32'hD000_0000 + i;
      step();
      in_valid = 1'b0;
      step();
      step();
    end
    chk("t5_full", rb_full, 1);
    chk("t5_ov", out_valid, 1);
    chk("t5_odata", out_data, 32'hD000_0000);
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    step();
    in_valid = 1'b0;
    chk("t5_no_wr", ram_wr_en, 0);
    chk("t5_dcount", drop_count, DC_EN ? 1 : 0);

    // drain
    out_ready = 1'b1;
    begin
      int n;
      n = 0;
      while (!rb_empty && n < 2000) begin
        step();
        n++;
      end
      chk("t5_drain_timeout", rb_empty, 1);
    end
    repeat (5) step();
    chk("t5_rp", rb_read_addr, DEPTH - 1);
    chk("t5_ov_end", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
